// File: rtl/wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_arbiter : register-file write port arbiter, ALU priority, buffered MEM,  |
// |              WAW kill and pending-destination mask.        Rev 1.0          |
// +----------------------------------------------------------------------------+

package const_pkg;
  localparam int REG_ADDR  = 5;
  localparam int REG_WIDTH = 32;
  localparam int REG_NUM   = 32;
endpackage

module wb_arbiter
  import const_pkg::*;
#(
  parameter int MEM_FIFO_DEPTH = 4,
  parameter bit DROP_ZERO_REG  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_alu_valid,
  input  logic [REG_ADDR-1:0]  i_alu_dest,
  input  logic [REG_WIDTH-1:0] i_alu_data,
  input  logic                 i_mem_valid,
  output logic                 o_mem_ready,
  input  logic [REG_ADDR-1:0]  i_mem_dest,
  input  logic [REG_WIDTH-1:0] i_mem_data,
  output logic                 o_write_enable,
  output logic [REG_ADDR-1:0]  o_write_select,
  output logic [REG_WIDTH-1:0] o_write_data,
  output logic [REG_NUM-1:0]   o_pending_mask
);

  localparam int c_PTR_W = $clog2(MEM_FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [REG_ADDR-1:0]       r_fifo_dest [MEM_FIFO_DEPTH];
  logic [REG_WIDTH-1:0]      r_fifo_data [MEM_FIFO_DEPTH];
  logic [MEM_FIFO_DEPTH-1:0] r_fifo_live;
  logic [c_PTR_W-1:0]        r_wr_ptr;
  logic [c_PTR_W-1:0]        r_rd_ptr;
  logic [c_CNT_W-1:0]        r_count;

  logic                      r_we;
  logic [REG_ADDR-1:0]       r_sel;
  logic [REG_WIDTH-1:0]      r_data;

  logic                      w_mem_ready;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_alu_we;
  logic                      w_head_we;
  logic                      w_same_dest;
  logic [REG_NUM-1:0]        w_mask;

  assign w_mem_ready = !rst && (r_count != c_CNT_W'(MEM_FIFO_DEPTH));
  assign w_push      = i_mem_valid && w_mem_ready;
  assign w_pop       = !i_alu_valid && (r_count != '0);
  assign w_same_dest = i_alu_valid && (i_alu_dest == i_mem_dest);
  assign w_alu_we    = !(DROP_ZERO_REG && (i_alu_dest == '0));
  assign w_head_we   = r_fifo_live[r_rd_ptr] &&
                       !(DROP_ZERO_REG && (r_fifo_dest[r_rd_ptr] == '0));

  // Payload storage needs no reset; liveness and pointers define occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_dest[r_wr_ptr] <= i_mem_dest;
      r_fifo_data[r_wr_ptr] <= i_mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo_live <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_data      <= '0;
    end else begin
      // ALU is younger than every queued MEM result, including one arriving now.
      if (i_alu_valid) begin
        for (int i = 0; i < MEM_FIFO_DEPTH; i++) begin
          if (r_fifo_dest[i] == i_alu_dest) begin
            r_fifo_live[i] <= 1'b0;
          end
        end
      end
      if (w_pop) begin
        r_fifo_live[r_rd_ptr] <= 1'b0;
        r_rd_ptr              <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_fifo_live[r_wr_ptr] <= !w_same_dest;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (i_alu_valid) begin
        r_we   <= w_alu_we;
        r_sel  <= i_alu_dest;
        r_data <= i_alu_data;
      end else if (w_pop) begin
        r_we   <= w_head_we;
        r_sel  <= r_fifo_dest[r_rd_ptr];
        r_data <= r_fifo_data[r_rd_ptr];
      end else begin
        r_we   <= 1'b0;
      end
    end
  end

  // Only occupied slots can be live, so no pointer-range test is needed here.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MEM_FIFO_DEPTH; i++) begin
      if (r_fifo_live[i]) begin
        w_mask[r_fifo_dest[i]] = 1'b1;
      end
    end
    if (r_we) begin
      w_mask[r_sel] = 1'b1;
    end
    if (DROP_ZERO_REG) begin
      w_mask[0] = 1'b0;
    end
  end

  assign o_mem_ready    = w_mem_ready;
  assign o_write_enable = r_we;
  assign o_write_select = r_sel;
  assign o_write_data   = r_data;
  assign o_pending_mask = w_mask;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wb_arbiter : directed and random checks of wb_arbiter against a         |
// |                 queue-based writeback model.                  Rev 1.0      |
// +----------------------------------------------------------------------------+
module tb_wb_arbiter;

  localparam int c_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_alu_valid;
  logic [4:0]  i_alu_dest;
  logic [31:0] i_alu_data;
  logic        i_mem_valid;
  logic        o_mem_ready;
  logic [4:0]  i_mem_dest;
  logic [31:0] i_mem_data;
  logic        o_write_enable;
  logic [4:0]  o_write_select;
  logic [31:0] o_write_data;
  logic [31:0] o_pending_mask;

  wb_arbiter #(.MEM_FIFO_DEPTH(c_DEPTH), .DROP_ZERO_REG(1'b1)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .i_alu_valid    (i_alu_valid),
    .i_alu_dest     (i_alu_dest),
    .i_alu_data     (i_alu_data),
    .i_mem_valid    (i_mem_valid),
    .o_mem_ready    (o_mem_ready),
    .i_mem_dest     (i_mem_dest),
    .i_mem_data     (i_mem_data),
    .o_write_enable (o_write_enable),
    .o_write_select (o_write_select),
    .o_write_data   (o_write_data),
    .o_pending_mask (o_pending_mask)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        q[$];
  logic        m_we   = 1'b0;
  logic [4:0]  m_sel  = '0;
  logic [31:0] m_data = '0;
  logic [31:0] rf [32];

  // Reference model plus per-cycle compare, stepped on every rising edge.
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_we = 1'b0; m_sel = '0; m_data = '0;
      end else begin
        bit   push_ok;
        ent_t e;
        push_ok = i_mem_valid && (q.size() != c_DEPTH);
        if (i_alu_valid) begin
          foreach (q[i]) if (q[i].dest == i_alu_dest) q[i].live = 1'b0;
          m_we = (i_alu_dest != 5'd0); m_sel = i_alu_dest; m_data = i_alu_data;
        end else if (q.size() != 0) begin
          e = q.pop_front();
          m_we = e.live && (e.dest != 5'd0); m_sel = e.dest; m_data = e.data;
        end else begin
          m_we = 1'b0;
        end
        if (push_ok) begin
          e.dest = i_mem_dest; e.data = i_mem_data;
          e.live = !(i_alu_valid && i_alu_dest == i_mem_dest);
          q.push_back(e);
        end
      end
      #2;
      begin
        logic [31:0] exp_mask;
        exp_mask = '0;
        foreach (q[i]) if (q[i].live) exp_mask[q[i].dest] = 1'b1;
        if (m_we) exp_mask[m_sel] = 1'b1;
        exp_mask[0] = 1'b0;
        check("model_we",   {31'd0, o_write_enable}, {31'd0, m_we});
        check("model_sel",  {27'd0, o_write_select}, {27'd0, m_sel});
        check("model_data", o_write_data, m_data);
        check("model_mask", o_pending_mask, exp_mask);
        check("model_ready", {31'd0, o_mem_ready},
              {31'd0, (!rst && q.size() != c_DEPTH)});
      end
      if (o_write_enable) rf[o_write_select] = o_write_data;
    end
  end

  task automatic drive(input bit r, input bit av, input logic [4:0] ad, input logic [31:0] adat,
                       input bit mv, input logic [4:0] md, input logic [31:0] mdat);
    rst = r; i_alu_valid = av; i_alu_dest = ad; i_alu_data = adat;
    i_mem_valid = mv; i_mem_dest = md; i_mem_data = mdat;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    // Reset held for two cycles
    for (int k = 0; k < 2; k++) begin
      step();
      check("rst_we", {31'd0, o_write_enable}, 32'd0);
      check("rst_mask", o_pending_mask, 32'd0);
      check("rst_ready", {31'd0, o_mem_ready}, 32'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 check("post_rst_ready", {31'd0, o_mem_ready}, 32'd1);
    step();

    // ALU only
    drive(0, 1, 5'd5, 32'hDEAD, 0, 0, 0);
    step();
    check("alu_we", {31'd0, o_write_enable}, 32'd1);
    check("alu_sel", {27'd0, o_write_select}, 32'd5);
    check("alu_data", o_write_data, 32'hDEAD);
    check("alu_mask", o_pending_mask, 32'h0000_0020);

    // Backpressure: ALU busy while five MEM results are offered
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 5'd20, 32'(k), 1, 5'(10 + k), 32'h100 + 32'(k));
      #1 check("bp_ready", {31'd0, o_mem_ready}, (k < 4) ? 32'd1 : 32'd0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("drain_we", {31'd0, o_write_enable}, 32'd1);
      check("drain_sel", {27'd0, o_write_select}, 32'(10 + k));
      check("drain_data", o_write_data, 32'h100 + 32'(k));
    end
    step();
    check("drain_idle_we", {31'd0, o_write_enable}, 32'd0);

    // WAW kill of an already queued MEM result
    drive(0, 0, 0, 0, 1, 5'd7, 32'h11);
    step();
    drive(0, 1, 5'd7, 32'h22, 0, 0, 0);
    step();
    check("waw_alu_we", {31'd0, o_write_enable}, 32'd1);
    check("waw_alu_data", o_write_data, 32'h22);
    check("waw_mask", o_pending_mask, 32'h0000_0080);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check("waw_pop_we", {31'd0, o_write_enable}, 32'd0);
    check("waw_rf7", rf[7], 32'h22);

    // Same-cycle kill
    drive(0, 1, 5'd3, 32'h33, 1, 5'd3, 32'h44);
    step();
    check("same_alu_data", o_write_data, 32'h33);
    check("same_mask", o_pending_mask, 32'h0000_0008);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check("same_pop_we", {31'd0, o_write_enable}, 32'd0);
    step();
    check("same_rf3", rf[3], 32'h33);

    // Zero register, then reset with three entries queued
    drive(0, 1, 5'd0, 32'h99, 0, 0, 0);
    step();
    check("zero_we", {31'd0, o_write_enable}, 32'd0);
    check("zero_mask", o_pending_mask, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 5'd20, 32'(k), 1, 5'(4 + k), 32'(k));
      step();
    end
    check("q3_mask", o_pending_mask, 32'h0010_0070);
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    check("midrst_we", {31'd0, o_write_enable}, 32'd0);
    check("midrst_mask", o_pending_mask, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("after_rst_we", {31'd0, o_write_enable}, 32'd0);
    end

    // Random traffic, narrow dest range to provoke kills and zero-register writes
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 149) == 0,
            $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
